s2p_sync_ctrl: RTL
==================

// Module: s2p_sync_ctrl
// PURPOSE
//  Word-alignment and lock controller for the 10-bit serial_parallel deserializer.
//  Watches each 10-bit word and hunts for a comma symbol, with either running disparity accepted.
//  Steers the deserializer word boundary with BIT_SLIP and declares lock after a comma train.
//  Once locked, forwards words downstream with VALID; drops lock on consecutive code errors.
// PARAMETERS
//  COMMA         10'b0011111010  K28.5 RD- pattern; ~COMMA (10'h305) is also accepted
//  LOCK_COUNT    4               consecutive commas needed for lock; legal range 2..15
//  ERR_LIMIT     3               consecutive CODE_ERR words in LOCKED before lock is dropped; range 1..15
//  HUNT_TIMEOUT  16              words in HUNT with no comma before a slip; range 2..255
// PORTS
//  CLK            in   1   single clock, rising edge
//  RESET          in   1   synchronous, active-low reset
//  WORD_IN        in   10  parallel word from deserializer
//  WORD_STB       in   1   1-cycle pulse: WORD_IN is a complete word this cycle
//  CODE_ERR       in   1   decoder flags WORD_IN as invalid; qualified by WORD_STB
//  DATA_OUT       out  10  forwarded word; holds last value when VALID=0
//  VALID          out  1   1-cycle pulse: DATA_OUT is new
//  LOCKED         out  1   high while FSM is in LOCKED
//  BIT_SLIP       out  1   1-cycle pulse: deserializer shifts word boundary by one bit
//  LOCK_LOSS_CNT  out  8   count of LOCKED->HUNT events (see CONFIGURATION)
// BEHAVIOUR
//  - All outputs registered. Outputs reflect the state after the edge that sampled the word (latency 1 clk).
//  - RESET=0 at posedge takes priority over everything. It forces state HUNT.
//    It forces DATA_OUT=0, VALID=0, LOCKED=0, BIT_SLIP=0, LOCK_LOSS_CNT=0 and clears all internal counters.
//    This holds in any state, including mid-LOCKED and mid-SLIP.
//  - is_com = (WORD_IN==COMMA) || (WORD_IN==~COMMA). A word with CODE_ERR=1 is never treated as a comma.
//  - Cycles with WORD_STB=0: state and counters hold; VALID=0 and BIT_SLIP=0.
//  - HUNT:
//    * stb & is_com -> CHECK with com_cnt=1 and hunt_cnt=0.
//    * stb & !is_com -> hunt_cnt+1. When HUNT_TIMEOUT non-comma words have been seen -> SLIP, hunt_cnt=0.
//  - SLIP: BIT_SLIP=1 for exactly this one cycle, then HUNT unconditionally. A WORD_STB arriving in SLIP is ignored.
//  - CHECK:
//    * stb & is_com -> com_cnt+1. When com_cnt reaches LOCK_COUNT -> LOCKED with err_cnt=0.
//    * stb & !is_com -> HUNT with com_cnt=0; no slip is issued.
//  - LOCKED:
//    * Every stb word is forwarded: DATA_OUT<=WORD_IN, VALID=1 on the next cycle. This includes commas and errored words.
//    * CODE_ERR -> err_cnt+1; a clean word clears err_cnt.
//    * The ERR_LIMIT-th consecutive error -> HUNT. That word is still forwarded. LOCKED=0 from the same edge.
//  - WORD_STB and the reset edge coincide: reset wins and the word is discarded.
//  - Internal counters are sized for their legal parameter range and never wrap inside it.
// CONFIGURATION
//  - `SYNC_CTRL_STATS_EN defined:
//    * LOCK_LOSS_CNT increments on each LOCKED->HUNT transition caused by errors.
//    * It saturates at 8'hFF and is cleared only by reset.
//  - Not defined: LOCK_LOSS_CNT is tied to 8'h00 and the counter logic is not built. All other behaviour is identical.
// TESTING
//  1. RESET=0 for 2 clks with random WORD_STB/WORD_IN -> all outputs 0. The first 3 commas after release do not lock.
//  2. 4 stb words 10'h0FA -> LOCKED=1 after the 4th. Then 10'h155 -> DATA_OUT=10'h155, VALID=1 for 1 clk.
//  3. Alternating 10'h0FA/10'h305 x4 -> lock after the 4th word. No BIT_SLIP at any point.
//  4. 3 commas, then 10'h155, then 4 commas -> HUNT after the data word. LOCKED rises only after the 8th word.
//  5. 32 stb words of 10'h155 from HUNT -> BIT_SLIP pulses after the 16th and 32nd words, 1 clk each. LOCKED stays 0.
//  6. Locked; then errors 2, clean 1, errors 3 -> LOCKED falls after the last error word, which is still forwarded.
//     LOCK_LOSS_CNT=1 with `SYNC_CTRL_STATS_EN, 0 without. Repeat with RESET pulsed mid-LOCKED -> all outputs 0 next clk.

Source files
------------

// File: rtl/s2p_sync_ctrl_if.sv
// Handshake/bus bundle between the serial_parallel deserializer side and the
// word-alignment/lock controller. Port names are kept from the original block.
interface s2p_sync_ctrl_if;
  logic [9:0] WORD_IN;
  logic       WORD_STB;
  logic       CODE_ERR;
  logic [9:0] DATA_OUT;
  logic       VALID;
  logic       LOCKED;
  logic       BIT_SLIP;
  logic [7:0] LOCK_LOSS_CNT;

  // Deserializer/decoder side: supplies words, observes alignment results.
  modport master (
    output WORD_IN, WORD_STB, CODE_ERR,
    input  DATA_OUT, VALID, LOCKED, BIT_SLIP, LOCK_LOSS_CNT
  );

  // Controller side.
  modport slave (
    input  WORD_IN, WORD_STB, CODE_ERR,
    output DATA_OUT, VALID, LOCKED, BIT_SLIP, LOCK_LOSS_CNT
  );
endinterface

// File: rtl/s2p_sync_ctrl.sv
// Word-alignment and lock controller for the 10-bit deserializer.
// Hunts for a comma (either disparity), slips the word boundary after a run of
// non-comma words, locks after a comma train and forwards words while locked.
// Optional lock-loss statistics counter: define SYNC_CTRL_STATS_EN.
module s2p_sync_ctrl #(
  parameter logic [9:0]  COMMA        = 10'b0011111010,
  parameter int unsigned LOCK_COUNT   = 4,
  parameter int unsigned ERR_LIMIT    = 3,
  parameter int unsigned HUNT_TIMEOUT = 16
) (
  input logic          CLK,
  input logic          RESET,
  s2p_sync_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SLIP   = 2'd1,
    ST_CHECK  = 2'd2,
    ST_LOCKED = 2'd3
  } state_e;

  // Terminal counts: the counters hold "events seen so far", so the event that
  // completes a run is detected when the counter already equals N-1.
  localparam logic [7:0] HUNT_LAST = 8'(HUNT_TIMEOUT - 1);
  localparam logic [3:0] LOCK_LAST = 4'(LOCK_COUNT - 1);
  localparam logic [3:0] ERR_LAST  = 4'(ERR_LIMIT - 1);

  state_e     state_q, state_d;
  logic [7:0] hunt_cnt_q, hunt_cnt_d;
  logic [3:0] com_cnt_q, com_cnt_d;
  logic [3:0] err_cnt_q, err_cnt_d;
  logic [9:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       locked_q, locked_d;
  logic       bit_slip_q, bit_slip_d;
  logic       lock_lost;
  logic       is_com;

  // Errored words never count as commas, regardless of their bit pattern.
  assign is_com = !bus.CODE_ERR && ((bus.WORD_IN == COMMA) || (bus.WORD_IN == ~COMMA));

  // Next-state, counter and output computation.
  always_comb begin
    state_d    = state_q;
    hunt_cnt_d = hunt_cnt_q;
    com_cnt_d  = com_cnt_q;
    err_cnt_d  = err_cnt_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    lock_lost  = 1'b0;
    unique case (state_q)
      ST_HUNT: begin
        if (bus.WORD_STB) begin
          if (is_com) begin
            state_d    = ST_CHECK;
            com_cnt_d  = 4'd1;
            hunt_cnt_d = '0;
          end else if (hunt_cnt_q == HUNT_LAST) begin
            state_d    = ST_SLIP;
            hunt_cnt_d = '0;
          end else begin
            hunt_cnt_d = hunt_cnt_q + 8'd1;
          end
        end
      end
      ST_SLIP: begin
        state_d = ST_HUNT;
      end
      ST_CHECK: begin
        if (bus.WORD_STB) begin
          if (is_com) begin
            if (com_cnt_q == LOCK_LAST) begin
              state_d   = ST_LOCKED;
              com_cnt_d = '0;
              err_cnt_d = '0;
            end else begin
              com_cnt_d = com_cnt_q + 4'd1;
            end
          end else begin
            state_d   = ST_HUNT;
            com_cnt_d = '0;
          end
        end
      end
      ST_LOCKED: begin
        if (bus.WORD_STB) begin
          data_d  = bus.WORD_IN;
          valid_d = 1'b1;
          if (bus.CODE_ERR) begin
            if (err_cnt_q == ERR_LAST) begin
              state_d    = ST_HUNT;
              err_cnt_d  = '0;
              hunt_cnt_d = '0;
              lock_lost  = 1'b1;
            end else begin
              err_cnt_d = err_cnt_q + 4'd1;
            end
          end else begin
            err_cnt_d = '0;
          end
        end
      end
      default: state_d = ST_HUNT;
    endcase
    locked_d   = (state_d == ST_LOCKED);
    bit_slip_d = (state_d == ST_SLIP);
  end

  // State, counters and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q    <= ST_HUNT;
      hunt_cnt_q <= '0;
      com_cnt_q  <= '0;
      err_cnt_q  <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      bit_slip_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hunt_cnt_q <= hunt_cnt_d;
      com_cnt_q  <= com_cnt_d;
      err_cnt_q  <= err_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      locked_q   <= locked_d;
      bit_slip_q <= bit_slip_d;
    end
  end

  assign bus.DATA_OUT = data_q;
  assign bus.VALID    = valid_q;
  assign bus.LOCKED   = locked_q;
  assign bus.BIT_SLIP = bit_slip_q;

`ifdef SYNC_CTRL_STATS_EN
  logic [7:0] loss_cnt_q, loss_cnt_d;

  // Saturating count of error-induced lock losses.
  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (lock_lost && (loss_cnt_q != 8'hFF)) loss_cnt_d = loss_cnt_q + 8'd1;
  end

  // Lock-loss counter register.
  always_ff @(posedge CLK) begin
    if (!RESET) loss_cnt_q <= '0;
    else        loss_cnt_q <= loss_cnt_d;
  end

  assign bus.LOCK_LOSS_CNT = loss_cnt_q;
`else
  logic unused_lock_lost;
  assign unused_lock_lost  = lock_lost;
  assign bus.LOCK_LOSS_CNT = 8'h00;
`endif

endmodule
